// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-stream sample gearbox.
package axis_pkg;

    typedef enum logic {
        STREAM = 1'b0,
        FLUSH  = 1'b1
    } gb_state_e;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-stream bundle: payload, valid, ready, last.
interface Axis_If #(
    parameter int W = 32
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic         last;

    modport Master (output data, output valid, output last, input ready);
    modport Slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_sample_gearbox.sv
// Sample-granular AXI-stream width converter. Samples are queued in a shift
// buffer of IN_SAMPLES+OUT_SAMPLES entries; an accepted input 'last' drains
// the buffer as a zero-padded final word carrying its valid-sample count.
module axis_sample_gearbox
    import axis_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int IN_SAMPLES   = 12,
    parameter int OUT_SAMPLES  = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    Axis_If.Slave                              data_in,
    Axis_If.Master                             data_out,
    output logic [$clog2(OUT_SAMPLES+1)-1:0]   data_out_samples
);

    localparam int CAP = IN_SAMPLES + OUT_SAMPLES;
    localparam int CW  = $clog2(CAP + 1);
    localparam int OCW = $clog2(OUT_SAMPLES + 1);

    if (SAMPLE_WIDTH < 1) begin : g_bad_sample_width
        $error("axis_sample_gearbox: SAMPLE_WIDTH must be at least 1");
    end
    if (IN_SAMPLES < 1 || OUT_SAMPLES < 1) begin : g_bad_sample_count
        $error("axis_sample_gearbox: IN_SAMPLES and OUT_SAMPLES must be at least 1");
    end

    logic [SAMPLE_WIDTH-1:0] sbuf    [CAP];
    logic [SAMPLE_WIDTH-1:0] sbuf_nx [CAP];
    logic [CW-1:0]           fill;
    logic [CW-1:0]           fill_base;
    logic [CW-1:0]           fill_nx;
    logic [CW-1:0]           out_cnt;
    logic [CW-1:0]           emit_cnt;
    gb_state_e               state;
    logic                    flushing;
    logic                    out_valid;
    logic                    out_last;
    logic                    out_ok;
    logic                    in_ready;
    logic                    in_ok;

    assign flushing  = (state == FLUSH);
    assign out_cnt   = CW'(min_u(32'(fill), unsigned'(OUT_SAMPLES)));
    assign out_valid = (fill >= CW'(OUT_SAMPLES)) || (flushing && (fill != '0));
    assign out_last  = flushing && (fill <= CW'(OUT_SAMPLES));
    assign out_ok    = out_valid && data_out.ready;
    assign emit_cnt  = out_ok ? out_cnt : '0;
    // Room is judged after the current output leaves, hence the path from data_out.ready.
    assign fill_base = fill - emit_cnt;
    assign in_ready  = !flushing &&
                       (({1'b0, fill_base} + (CW+1)'(IN_SAMPLES)) <= (CW+1)'(CAP));
    assign in_ok     = data_in.valid && in_ready;
    assign fill_nx   = fill_base + (in_ok ? CW'(IN_SAMPLES) : '0);

    assign data_in.ready    = in_ready;
    assign data_out.valid   = out_valid;
    assign data_out.last    = out_last;
    assign data_out_samples = out_valid ? OCW'(out_cnt) : '0;

    // Present the head of the buffer, zeroing slots beyond the fill level.
    always_comb begin
        data_out.data = '0;
        for (int k = 0; k < OUT_SAMPLES; k++) begin
            if (k < int'(fill)) begin
                data_out.data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sbuf[k];
            end
        end
    end

    // Next buffer: shift out the emitted samples, then append the input beat at fill_base.
    always_comb begin
        for (int i = 0; i < CAP; i++) begin
            sbuf_nx[i] = '0;
        end
        for (int s = 0; s <= OUT_SAMPLES; s++) begin
            if (int'(emit_cnt) == s) begin
                for (int i = 0; i + s < CAP; i++) begin
                    sbuf_nx[i] = sbuf[i + s];
                end
            end
        end
        for (int j = 0; j < IN_SAMPLES; j++) begin
            for (int p = 0; p + j < CAP; p++) begin
                if (in_ok && (int'(fill_base) == p)) begin
                    sbuf_nx[p + j] = data_in.data[j*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                end
            end
        end
    end

    // Buffer, fill level and stream/flush state; reset discards everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill  <= '0;
            state <= STREAM;
            for (int i = 0; i < CAP; i++) begin
                sbuf[i] <= '0;
            end
        end else begin
            fill <= fill_nx;
            for (int i = 0; i < CAP; i++) begin
                sbuf[i] <= sbuf_nx[i];
            end
            if (in_ok && data_in.last) begin
                state <= FLUSH;
            end else if (out_ok && out_last) begin
                state <= STREAM;
            end
        end
    end

endmodule

// File: tb/tb_axis_sample_gearbox.sv
// Bench for axis_sample_gearbox: three instances (12->16, 16->12, 1->7),
// each with a sample scoreboard fed by accepted input beats.
module tb_axis_sample_gearbox;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    Axis_If #(.W(192)) a_in ();
    Axis_If #(.W(256)) a_out ();
    logic [4:0]        a_cnt;
    Axis_If #(.W(256)) b_in ();
    Axis_If #(.W(192)) b_out ();
    logic [3:0]        b_cnt;
    Axis_If #(.W(16))  c_in ();
    Axis_If #(.W(112)) c_out ();
    logic [2:0]        c_cnt;

    axis_sample_gearbox #(.SAMPLE_WIDTH(16), .IN_SAMPLES(12), .OUT_SAMPLES(16)) u_a (
        .clk(clk), .reset(reset), .data_in(a_in), .data_out(a_out), .data_out_samples(a_cnt));
    axis_sample_gearbox #(.SAMPLE_WIDTH(16), .IN_SAMPLES(16), .OUT_SAMPLES(12)) u_b (
        .clk(clk), .reset(reset), .data_in(b_in), .data_out(b_out), .data_out_samples(b_cnt));
    axis_sample_gearbox #(.SAMPLE_WIDTH(16), .IN_SAMPLES(1), .OUT_SAMPLES(7)) u_c (
        .clk(clk), .reset(reset), .data_in(c_in), .data_out(c_out), .data_out_samples(c_cnt));

    int qa[$], bla[$], qb[$], blb[$], qc[$], blc[$];
    int opena, openb, openc;
    int a_words, a_lasts, a_last_cnt, b_words, b_lasts, b_last_cnt, c_words, c_lasts;
    int seq_a, seq_b, seq_c;
    logic a_hold, b_hold, c_hold;
    logic [255:0] a_hd;
    logic [191:0] b_hd;
    logic [111:0] c_hd;
    logic a_hl, b_hl, c_hl;
    logic [4:0] a_hc;
    logic [3:0] b_hc;
    logic [2:0] c_hc;

    // Scoreboard and protocol monitor, 12->16 instance.
    always @(negedge clk) begin : mon_a
        int fl, base, ec;
        bit el, flush, exp_v, exp_r, in_acc, under;
        logic [255:0] ew;
        if (reset) begin
            qa.delete(); bla.delete(); opena = 0; a_hold = 1'b0;
        end else begin
            fl = qa.size(); flush = (bla.size() > 0);
            exp_v = (fl >= 16) || (flush && fl > 0);
            base = fl - ((exp_v && a_out.ready) ? ((fl < 16) ? fl : 16) : 0);
            exp_r = !flush && (base + 12 <= 28);
            checks++;
            if (a_out.valid !== exp_v || a_in.ready !== exp_r) begin
                errors++;
                $display("FAIL a_flags valid=%b ready=%b required valid=%b ready=%b", a_out.valid, a_in.ready, exp_v, exp_r);
            end
            in_acc = a_in.valid && a_in.ready;
            if (in_acc) begin
                checks++;
                if (flush) begin errors++; $display("FAIL a_accept_in_flush accepted=1 required=0"); end
            end
            if (a_hold) begin
                checks++;
                if (a_out.valid !== 1'b1 || a_out.data !== a_hd || a_out.last !== a_hl || a_cnt !== a_hc) begin
                    errors++;
                    $display("FAIL a_stable data=%h last=%b cnt=%0d required data=%h last=%b cnt=%0d", a_out.data, a_out.last, a_cnt, a_hd, a_hl, a_hc);
                end
            end
            if (a_out.valid && a_out.ready) begin
                if (flush) begin ec = (bla[0] < 16) ? bla[0] : 16; el = (bla[0] <= 16); end
                else begin ec = 16; el = 1'b0; end
                checks++;
                if (a_cnt !== 5'(ec) || a_out.last !== el) begin
                    errors++;
                    $display("FAIL a_count cnt=%0d last=%b required cnt=%0d last=%b", a_cnt, a_out.last, ec, el);
                end
                ew = '0; under = 1'b0;
                for (int k = 0; k < ec; k++) begin
                    if (qa.size() == 0) under = 1'b1;
                    else ew[k*16 +: 16] = 16'(qa.pop_front());
                end
                checks++;
                if (under || a_out.data !== ew) begin
                    errors++;
                    $display("FAIL a_word data=%h required=%h", a_out.data, ew);
                end
                if (flush) begin bla[0] = bla[0] - ec; if (bla[0] <= 0) bla.delete(0); end
                else opena = opena - ec;
                a_words++;
                if (el) begin a_lasts++; a_last_cnt = ec; end
            end
            if (in_acc) begin
                for (int j = 0; j < 12; j++) qa.push_back(int'(a_in.data[j*16 +: 16]));
                opena += 12;
                if (a_in.last) begin bla.push_back(opena); opena = 0; end
            end
            a_hold = a_out.valid && !a_out.ready;
            a_hd = a_out.data; a_hl = a_out.last; a_hc = a_cnt;
        end
    end

    // Scoreboard and protocol monitor, 16->12 instance.
    always @(negedge clk) begin : mon_b
        int fl, base, ec;
        bit el, flush, exp_v, exp_r, in_acc, under;
        logic [191:0] ew;
        if (reset) begin
            qb.delete(); blb.delete(); openb = 0; b_hold = 1'b0;
        end else begin
            fl = qb.size(); flush = (blb.size() > 0);
            exp_v = (fl >= 12) || (flush && fl > 0);
            base = fl - ((exp_v && b_out.ready) ? ((fl < 12) ? fl : 12) : 0);
            exp_r = !flush && (base + 16 <= 28);
            checks++;
            if (b_out.valid !== exp_v || b_in.ready !== exp_r) begin
                errors++;
                $display("FAIL b_flags valid=%b ready=%b required valid=%b ready=%b", b_out.valid, b_in.ready, exp_v, exp_r);
            end
            in_acc = b_in.valid && b_in.ready;
            if (in_acc) begin
                checks++;
                if (flush) begin errors++; $display("FAIL b_accept_in_flush accepted=1 required=0"); end
            end
            if (b_hold) begin
                checks++;
                if (b_out.valid !== 1'b1 || b_out.data !== b_hd || b_out.last !== b_hl || b_cnt !== b_hc) begin
                    errors++;
                    $display("FAIL b_stable data=%h last=%b cnt=%0d required data=%h last=%b cnt=%0d", b_out.data, b_out.last, b_cnt, b_hd, b_hl, b_hc);
                end
            end
            if (b_out.valid && b_out.ready) begin
                if (flush) begin ec = (blb[0] < 12) ? blb[0] : 12; el = (blb[0] <= 12); end
                else begin ec = 12; el = 1'b0; end
                checks++;
                if (b_cnt !== 4'(ec) || b_out.last !== el) begin
                    errors++;
                    $display("FAIL b_count cnt=%0d last=%b required cnt=%0d last=%b", b_cnt, b_out.last, ec, el);
                end
                ew = '0; under = 1'b0;
                for (int k = 0; k < ec; k++) begin
                    if (qb.size() == 0) under = 1'b1;
                    else ew[k*16 +: 16] = 16'(qb.pop_front());
                end
                checks++;
                if (under || b_out.data !== ew) begin
                    errors++;
                    $display("FAIL b_word data=%h required=%h", b_out.data, ew);
                end
                if (flush) begin blb[0] = blb[0] - ec; if (blb[0] <= 0) blb.delete(0); end
                else openb = openb - ec;
                b_words++;
                if (el) begin b_lasts++; b_last_cnt = ec; end
            end
            if (in_acc) begin
                for (int j = 0; j < 16; j++) qb.push_back(int'(b_in.data[j*16 +: 16]));
                openb += 16;
                if (b_in.last) begin blb.push_back(openb); openb = 0; end
            end
            b_hold = b_out.valid && !b_out.ready;
            b_hd = b_out.data; b_hl = b_out.last; b_hc = b_cnt;
        end
    end

    // Scoreboard and protocol monitor, 1->7 instance.
    always @(negedge clk) begin : mon_c
        int fl, base, ec;
        bit el, flush, exp_v, exp_r, in_acc, under;
        logic [111:0] ew;
        if (reset) begin
            qc.delete(); blc.delete(); openc = 0; c_hold = 1'b0;
        end else begin
            fl = qc.size(); flush = (blc.size() > 0);
            exp_v = (fl >= 7) || (flush && fl > 0);
            base = fl - ((exp_v && c_out.ready) ? ((fl < 7) ? fl : 7) : 0);
            exp_r = !flush && (base + 1 <= 8);
            checks++;
            if (c_out.valid !== exp_v || c_in.ready !== exp_r) begin
                errors++;
                $display("FAIL c_flags valid=%b ready=%b required valid=%b ready=%b", c_out.valid, c_in.ready, exp_v, exp_r);
            end
            in_acc = c_in.valid && c_in.ready;
            if (in_acc) begin
                checks++;
                if (flush) begin errors++; $display("FAIL c_accept_in_flush accepted=1 required=0"); end
            end
            if (c_hold) begin
                checks++;
                if (c_out.valid !== 1'b1 || c_out.data !== c_hd || c_out.last !== c_hl || c_cnt !== c_hc) begin
                    errors++;
                    $display("FAIL c_stable data=%h last=%b cnt=%0d required data=%h last=%b cnt=%0d", c_out.data, c_out.last, c_cnt, c_hd, c_hl, c_hc);
                end
            end
            if (c_out.valid && c_out.ready) begin
                if (flush) begin ec = (blc[0] < 7) ? blc[0] : 7; el = (blc[0] <= 7); end
                else begin ec = 7; el = 1'b0; end
                checks++;
                if (c_cnt !== 3'(ec) || c_out.last !== el) begin
                    errors++;
                    $display("FAIL c_count cnt=%0d last=%b required cnt=%0d last=%b", c_cnt, c_out.last, ec, el);
                end
                ew = '0; under = 1'b0;
                for (int k = 0; k < ec; k++) begin
                    if (qc.size() == 0) under = 1'b1;
                    else ew[k*16 +: 16] = 16'(qc.pop_front());
                end
                checks++;
                if (under || c_out.data !== ew) begin
                    errors++;
                    $display("FAIL c_word data=%h required=%h", c_out.data, ew);
                end
                if (flush) begin blc[0] = blc[0] - ec; if (blc[0] <= 0) blc.delete(0); end
                else openc = openc - ec;
                c_words++;
                if (el) c_lasts++;
            end
            if (in_acc) begin
                qc.push_back(int'(c_in.data));
                openc += 1;
                if (c_in.last) begin blc.push_back(openc); openc = 0; end
            end
            c_hold = c_out.valid && !c_out.ready;
            c_hd = c_out.data; c_hl = c_out.last; c_hc = c_cnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input bit lst);
        a_in.valid = 1'b1;
        a_in.last  = lst;
        for (int j = 0; j < 12; j++) begin a_in.data[j*16 +: 16] = 16'(seq_a); seq_a++; end
    endtask

    task automatic wait_a();
        int n = 0;
        do begin @(negedge clk); n++; end while (!a_in.ready && n < 200);
        checks++;
        if (!a_in.ready) begin errors++; $display("FAIL a_in_timeout ready=%b required=1", a_in.ready); end
        tick();
    endtask

    task automatic load_b(input bit lst);
        b_in.valid = 1'b1;
        b_in.last  = lst;
        for (int j = 0; j < 16; j++) begin b_in.data[j*16 +: 16] = 16'(seq_b); seq_b++; end
    endtask

    task automatic wait_b();
        int n = 0;
        do begin @(negedge clk); n++; end while (!b_in.ready && n < 200);
        checks++;
        if (!b_in.ready) begin errors++; $display("FAIL b_in_timeout ready=%b required=1", b_in.ready); end
        tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if (a_out.valid !== 1'b0 || a_out.last !== 1'b0 || a_cnt !== 5'd0 || a_in.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_a valid=%b last=%b cnt=%0d ready=%b required 0 0 0 1", a_out.valid, a_out.last, a_cnt, a_in.ready);
        end
        checks++;
        if (b_out.valid !== 1'b0 || b_out.last !== 1'b0 || b_cnt !== 4'd0 || b_in.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_b valid=%b last=%b cnt=%0d ready=%b required 0 0 0 1", b_out.valid, b_out.last, b_cnt, b_in.ready);
        end
        checks++;
        if (c_out.valid !== 1'b0 || c_out.last !== 1'b0 || c_cnt !== 3'd0 || c_in.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_c valid=%b last=%b cnt=%0d ready=%b required 0 0 0 1", c_out.valid, c_out.last, c_cnt, c_in.ready);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (a_out.data !== 256'd0 || a_out.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_a_data data=%h valid=%b required 0 0", a_out.data, a_out.valid);
        end
    endtask

    task automatic drain_a();
        int n = 0;
        a_out.ready = 1'b1;
        while ((qa.size() > 0 || bla.size() > 0) && n < 300) begin tick(); n++; end
        checks++;
        if (qa.size() != 0 || bla.size() != 0) begin errors++; $display("FAIL a_drain left=%0d required=0", qa.size()); end
    endtask

    task automatic drain_b();
        int n = 0;
        b_out.ready = 1'b1;
        while ((qb.size() > 0 || blb.size() > 0) && n < 300) begin tick(); n++; end
        checks++;
        if (qb.size() != 0 || blb.size() != 0) begin errors++; $display("FAIL b_drain left=%0d required=0", qb.size()); end
    endtask

    task automatic drain_c();
        int n = 0;
        c_out.ready = 1'b1;
        while ((qc.size() > 0 || blc.size() > 0) && n < 300) begin tick(); n++; end
        checks++;
        if (qc.size() != 0 || blc.size() != 0) begin errors++; $display("FAIL c_drain left=%0d required=0", qc.size()); end
    endtask

    task automatic test_exact_burst();
        a_words = 0; a_lasts = 0; a_last_cnt = 0; seq_a = 0;
        a_out.ready = 1'b1;
        for (int b = 0; b < 4; b++) begin load_a(b == 3); wait_a(); end
        a_in.valid = 1'b0; a_in.last = 1'b0;
        drain_a();
        checks++;
        if (a_words != 3 || a_lasts != 1 || a_last_cnt != 16) begin
            errors++;
            $display("FAIL exact_burst words=%0d lasts=%0d last_cnt=%0d required 3 1 16", a_words, a_lasts, a_last_cnt);
        end
    endtask

    task automatic test_partial_burst();
        a_words = 0; a_lasts = 0; a_last_cnt = 0; seq_a = 0;
        a_out.ready = 1'b1;
        for (int b = 0; b < 5; b++) begin load_a(b == 4); wait_a(); end
        a_in.valid = 1'b0; a_in.last = 1'b0;
        drain_a();
        checks++;
        if (a_words != 4 || a_lasts != 1 || a_last_cnt != 12) begin
            errors++;
            $display("FAIL partial_burst words=%0d lasts=%0d last_cnt=%0d required 4 1 12", a_words, a_lasts, a_last_cnt);
        end
    endtask

    task automatic test_downsize();
        b_words = 0; b_lasts = 0; b_last_cnt = 0; seq_b = 0;
        b_out.ready = 1'b1;
        for (int b = 0; b < 3; b++) begin load_b(1'b0); wait_b(); end
        b_in.valid = 1'b0;
        drain_b();
        checks++;
        if (b_words != 4 || b_lasts != 0) begin
            errors++;
            $display("FAIL downsize words=%0d lasts=%0d required 4 0", b_words, b_lasts);
        end
        b_words = 0;
        b_out.ready = 1'b0;
        load_b(1'b0); wait_b();
        load_b(1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (b_in.ready !== 1'b0) begin errors++; $display("FAIL downsize_full ready=%b required=0", b_in.ready); end
            tick();
        end
        b_out.ready = 1'b1;
        wait_b();
        load_b(1'b1); wait_b();
        b_in.valid = 1'b0; b_in.last = 1'b0;
        drain_b();
        checks++;
        if (b_words != 4 || b_lasts != 1 || b_last_cnt != 12) begin
            errors++;
            $display("FAIL downsize_flush words=%0d lasts=%0d last_cnt=%0d required 4 1 12", b_words, b_lasts, b_last_cnt);
        end
    endtask

    task automatic test_random_backpressure();
        int sent = 0;
        int cyc = 0;
        bit acc;
        seq_c = 0; c_words = 0; c_lasts = 0;
        c_in.valid = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            if (!c_in.valid && $urandom_range(0, 3) != 0) begin
                c_in.valid = 1'b1;
                c_in.data  = 16'(seq_c);
                seq_c++;
                c_in.last  = (sent == 999) || ($urandom_range(0, 11) == 0);
            end
            c_out.ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            acc = c_in.valid && c_in.ready;
            tick();
            if (acc) begin sent++; c_in.valid = 1'b0; c_in.last = 1'b0; end
            cyc++;
        end
        c_in.valid = 1'b0;
        checks++;
        if (sent != 1000) begin errors++; $display("FAIL random_sent sent=%0d required=1000", sent); end
        drain_c();
        checks++;
        if (c_words < 143 || c_lasts < 1) begin
            errors++;
            $display("FAIL random_words words=%0d lasts=%0d required at least 143 1", c_words, c_lasts);
        end
    endtask

    task automatic test_throughput();
        bit acc;
        seq_a = 0;
        a_out.ready = 1'b1;
        load_a(1'b0);
        for (int c = 0; c < 48; c++) begin
            if (c == 8) a_words = 0;
            @(negedge clk);
            acc = a_in.ready;
            tick();
            if (acc) load_a(1'b0);
        end
        checks++;
        if (a_words != 30) begin errors++; $display("FAIL throughput words=%0d required=30", a_words); end
        a_in.last = 1'b1;
        wait_a();
        a_in.valid = 1'b0; a_in.last = 1'b0;
        drain_a();
    endtask

    task automatic test_reset_midburst();
        seq_a = 0;
        a_out.ready = 1'b1;
        for (int b = 0; b < 3; b++) begin load_a(1'b0); wait_a(); end
        a_in.valid = 1'b0;
        a_out.ready = 1'b0;
        @(negedge clk);
        checks++;
        if (a_out.valid !== 1'b1 || a_cnt !== 5'd16) begin
            errors++;
            $display("FAIL midburst_pre valid=%b cnt=%0d required 1 16", a_out.valid, a_cnt);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (a_out.valid !== 1'b0 || a_out.last !== 1'b0 || a_cnt !== 5'd0 || a_in.ready !== 1'b1 || a_out.data !== 256'd0) begin
            errors++;
            $display("FAIL midburst_reset valid=%b last=%b cnt=%0d ready=%b data=%h required 0 0 0 1 0", a_out.valid, a_out.last, a_cnt, a_in.ready, a_out.data);
        end
        tick(); tick();
        reset = 1'b0;
        tick();
        a_words = 0; a_lasts = 0; a_last_cnt = 0; seq_a = 0;
        a_out.ready = 1'b1;
        load_a(1'b0); wait_a();
        load_a(1'b1); wait_a();
        a_in.valid = 1'b0; a_in.last = 1'b0;
        drain_a();
        checks++;
        if (a_words != 2 || a_lasts != 1 || a_last_cnt != 8) begin
            errors++;
            $display("FAIL midburst_restart words=%0d lasts=%0d last_cnt=%0d required 2 1 8", a_words, a_lasts, a_last_cnt);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        a_in.valid = 1'b0; a_in.last = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
        b_in.valid = 1'b0; b_in.last = 1'b0; b_in.data = '0; b_out.ready = 1'b0;
        c_in.valid = 1'b0; c_in.last = 1'b0; c_in.data = '0; c_out.ready = 1'b0;
        a_words = 0; b_words = 0; c_words = 0;
        test_reset();
        test_exact_burst();
        test_partial_burst();
        test_downsize();
        test_random_backpressure();
        test_throughput();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
